// File: rtl/riot_pkg.sv
// Shared encodings for the RIOT-style port/timer block: prescale selects,
// divisors, address-field bit positions and flag-byte layout.
package riot_pkg;

    typedef enum logic [1:0] {
        PS_DIV1    = 2'd0,
        PS_DIV8    = 2'd1,
        PS_DIV64   = 2'd2,
        PS_DIV1024 = 2'd3
    } prescale_e;

    localparam int unsigned DIV_1    = 1;
    localparam int unsigned DIV_8    = 8;
    localparam int unsigned DIV_64   = 64;
    localparam int unsigned DIV_1024 = 1024;
    localparam int unsigned PS_CNT_W = 10;

    // Address fields
    localparam int unsigned A_SPACE   = 4;
    localparam int unsigned A_TIMER   = 3;
    localparam int unsigned A_TIE     = 2;
    localparam int unsigned A_PORT_HI = 2;
    localparam int unsigned A_PORT_LO = 1;
    localparam int unsigned A_REG     = 0;
    localparam int unsigned A_EPOL    = 0;
    localparam int unsigned A_EIE     = 1;

    // Flag byte
    localparam int unsigned FLAG_T = 7;
    localparam int unsigned FLAG_E = 6;

    // Terminal count of the prescale counter for a given select
    function automatic logic [PS_CNT_W-1:0] div_limit(input prescale_e ps);
        case (ps)
            PS_DIV1:  return PS_CNT_W'(DIV_1 - 1);
            PS_DIV8:  return PS_CNT_W'(DIV_8 - 1);
            PS_DIV64: return PS_CNT_W'(DIV_64 - 1);
            default:  return PS_CNT_W'(DIV_1024 - 1);
        endcase
    endfunction

endpackage

// File: rtl/riot_interval_timer.sv
// 8-bit interval timer: prescale counter, down-counter, underflow handling
// (forced /1 after underflow until reload) and the timer flag.
module riot_interval_timer
    import riot_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  prescale_e  psel,
    input  logic       clr,
    output logic [7:0] timer,
    output logic       tflag
);

    logic [PS_CNT_W-1:0] cnt_q;
    logic [PS_CNT_W-1:0] limit;
    prescale_e           ps_q;
    logic                forced_q;
    logic                tick;

    assign limit = forced_q ? '0 : div_limit(ps_q);
    assign tick  = (cnt_q == limit);

    // A load overrides any concurrent underflow; a flag set beats a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            ps_q     <= PS_DIV1024;
            forced_q <= 1'b0;
            timer    <= 8'hFF;
            tflag    <= 1'b0;
        end else if (load) begin
            cnt_q    <= '0;
            ps_q     <= psel;
            forced_q <= 1'b0;
            timer    <= load_val;
            tflag    <= 1'b0;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + PS_CNT_W'(1);
            if (tick) begin
                if (timer == 8'h00) begin
                    timer    <= 8'hFF;
                    forced_q <= 1'b1;
                end else begin
                    timer <= timer - 8'd1;
                end
            end
            if (tick && timer == 8'h00) tflag <= 1'b1;
            else if (clr)               tflag <= 1'b0;
        end
    end

endmodule

// File: rtl/riot_port_timer.sv
// 6530/6532-style I/O ports plus interval timer with registered irq_n.
// Optional PI[PORT_W-1] edge detector enabled by RIOT_EDGE_DETECT_EN.
module riot_port_timer
    import riot_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned PORT_W    = 8
) (
    input  logic                        phi2,
    input  logic                        rst_n,
    input  logic                        cs,
    input  logic                        we_n,
    input  logic [4:0]                  A,
    input  logic [7:0]                  DI,
    output logic [7:0]                  DO,
    output logic                        OE,
    input  logic [NUM_PORTS*PORT_W-1:0] PI,
    output logic [NUM_PORTS*PORT_W-1:0] PO,
    output logic [NUM_PORTS*PORT_W-1:0] DDR,
    output logic                        irq_n
);

    logic [1:0] p;
    logic       port_sel, tmr_sel, wr, rd;
    logic       tmr_load, tmr_clr, flag_rd;
    logic       tie_q, tflag, eflag, eie;
    logic [7:0] tmr_val, port_rd, flag_byte;

    assign p        = A[A_PORT_HI:A_PORT_LO];
    assign port_sel = ~A[A_SPACE] & ~A[A_TIMER];
    assign tmr_sel  = ~A[A_SPACE] &  A[A_TIMER];
    assign wr       = cs & ~we_n;
    assign rd       = cs &  we_n;
    assign OE       = rd;
    assign tmr_load = wr & tmr_sel;
    assign tmr_clr  = rd & tmr_sel & ~A[A_REG];
    assign flag_rd  = rd & tmr_sel &  A[A_REG];

    // Port data / direction registers; out-of-range ports ignore writes
    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            PO  <= '0;
            DDR <= '0;
        end else if (wr && port_sel) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (p == 2'(i)) begin
                    if (A[A_REG]) DDR[i*PORT_W +: PORT_W] <= DI[PORT_W-1:0];
                    else          PO[i*PORT_W +: PORT_W]  <= DI[PORT_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n)                    tie_q <= 1'b0;
        else if (tmr_load || tmr_clr)  tie_q <= A[A_TIE];
    end

    riot_interval_timer u_timer (
        .clk      (phi2),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (DI),
        .psel     (prescale_e'(A[1:0])),
        .clr      (tmr_clr),
        .timer    (tmr_val),
        .tflag    (tflag)
    );

`ifdef RIOT_EDGE_DETECT_EN
    logic prev_q, edge_pol_q, eie_q, eflag_q, edge_hit;

    assign edge_hit = edge_pol_q ? ( PI[PORT_W-1] & ~prev_q)
                                 : (~PI[PORT_W-1] &  prev_q);

    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= 1'b0;
            edge_pol_q <= 1'b0;
            eie_q      <= 1'b0;
            eflag_q    <= 1'b0;
        end else begin
            prev_q <= PI[PORT_W-1];
            if (wr && A[A_SPACE]) begin
                edge_pol_q <= A[A_EPOL];
                eie_q      <= A[A_EIE];
            end
            if (edge_hit)     eflag_q <= 1'b1;
            else if (flag_rd) eflag_q <= 1'b0;
        end
    end

    assign eflag = eflag_q;
    assign eie   = eie_q;
`else
    assign eflag = 1'b0;
    assign eie   = 1'b0;
`endif

    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) irq_n <= 1'b1;
        else        irq_n <= ~((tflag & tie_q) | (eflag & eie));
    end

    // Read data: pins for inputs, PO for outputs, zero-extended
    always_comb begin
        port_rd = 8'h00;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (p == 2'(i)) begin
                if (A[A_REG]) port_rd = 8'(DDR[i*PORT_W +: PORT_W]);
                else          port_rd = 8'((PO[i*PORT_W +: PORT_W] & DDR[i*PORT_W +: PORT_W]) |
                                           (PI[i*PORT_W +: PORT_W] & ~DDR[i*PORT_W +: PORT_W]));
            end
        end
    end

    always_comb begin
        flag_byte         = 8'h00;
        flag_byte[FLAG_T] = tflag;
        flag_byte[FLAG_E] = eflag;
    end

    always_comb begin
        DO = 8'h00;
        if (port_sel)     DO = port_rd;
        else if (tmr_sel) DO = A[A_REG] ? flag_byte : tmr_val;
    end

endmodule
